board_state_ctrl: RTL

//  Owns the registered 3x3 tic-tac-toe board and drives pos1..pos9 into detect_win.

---
 rtl/board_state_ctrl.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/board_state_ctrl.sv
// board_state_ctrl
//   Owns the registered 3x3 tic-tac-toe board and drives pos1..pos9 into an
//   external combinational winner detector. It accepts one move request per
//   cycle and validates it. A valid move writes the mover's mark. The next
//   cycle (CHECK) samples winner/who_win. The controller then either
//   alternates the turn or freezes the board in OVER on a win or a
//   full-board draw.
//   Optional feature macro: UNDO_EN (adds `undo` and a one-deep last-move
//   register).
// Ports
//   clk, rst              rising-edge clock, synchronous active-high reset
//   new_game              clear board and return to PLAY (drops same-cycle move)
//   move_valid, move_pos  move request strobe and square 1..9 (row-major)
//   winner, who_win       from the detector, combinational on pos*
//   undo (UNDO_EN only)   take back the last accepted move
//   pos1..pos9            square contents: 00 empty, 01 X, 10 O
//   turn                  mark of the player to move
//   move_accept/reject    1-cycle result pulses
//   move_count            squares filled, 0..9
//   game_over, win_mark, draw  end-of-game status
module board_state_ctrl #(
  parameter logic [1:0] FIRST_PLAYER = 2'b01
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       new_game,
  input  logic       move_valid,
  input  logic [3:0] move_pos,
  input  logic       winner,
  input  logic [1:0] who_win,
`ifdef UNDO_EN
  input  logic       undo,
`endif
  output logic [1:0] pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9,
  output logic [1:0] turn,
  output logic       move_accept,
  output logic       move_reject,
  output logic [3:0] move_count,
  output logic       game_over,
  output logic [1:0] win_mark,
  output logic       draw
);

  typedef enum logic [1:0] {PLAY = 2'd0, CHECK = 2'd1, OVER = 2'd2} state_t;

  state_t          state, state_nxt;
  logic [8:0][1:0] board, board_nxt;
  logic [1:0]      turn_nxt, win_mark_nxt;
  logic [3:0]      count_nxt;
  logic            accept_nxt, reject_nxt, over_nxt, draw_nxt;

  logic [3:0] idx;
  logic       pos_ok, sq_free, do_move, do_undo;

  assign idx     = move_pos - 4'd1;
  assign pos_ok  = (move_pos >= 4'd1) && (move_pos <= 4'd9);
  assign sq_free = pos_ok && (board[idx] == 2'b00);

`ifdef UNDO_EN
  logic       last_vld, last_vld_nxt;
  logic [3:0] last_idx, last_idx_nxt;
  assign do_undo = (state == PLAY) && undo && last_vld && (move_count != 4'd0);
`else
  assign do_undo = 1'b0;
`endif

  // An undo in the same cycle as a move request wins; the move is refused.
  assign do_move = (state == PLAY) && move_valid && sq_free && !do_undo;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= PLAY;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (new_game) state_nxt = PLAY;
    else begin
      case (state)
        PLAY:    if (do_move) state_nxt = CHECK;
        CHECK:   state_nxt = (winner || move_count == 4'd9) ? OVER : PLAY;
        OVER:    state_nxt = OVER;
        default: state_nxt = PLAY;
      endcase
    end
  end

  // Output / datapath next values
  always_comb begin
    board_nxt    = board;
    turn_nxt     = turn;
    count_nxt    = move_count;
    accept_nxt   = 1'b0;
    reject_nxt   = 1'b0;
    over_nxt     = game_over;
    draw_nxt     = draw;
    win_mark_nxt = win_mark;
`ifdef UNDO_EN
    last_vld_nxt = last_vld;
    last_idx_nxt = last_idx;
`endif
    if (new_game) begin
      board_nxt    = '0;
      turn_nxt     = FIRST_PLAYER;
      count_nxt    = 4'd0;
      over_nxt     = 1'b0;
      draw_nxt     = 1'b0;
      win_mark_nxt = 2'b00;
`ifdef UNDO_EN
      last_vld_nxt = 1'b0;
`endif
    end else begin
      reject_nxt = move_valid && !do_move;
      if (do_move) begin
        board_nxt[idx] = turn;
        count_nxt      = move_count + 4'd1;
        accept_nxt     = 1'b1;
`ifdef UNDO_EN
        last_vld_nxt   = 1'b1;
        last_idx_nxt   = idx;
`endif
      end
`ifdef UNDO_EN
      if (do_undo) begin
        board_nxt[last_idx] = 2'b00;
        count_nxt           = move_count - 4'd1;
        turn_nxt            = ~turn;
        last_vld_nxt        = 1'b0;
      end
`endif
      // The winner check precedes the draw check so a win on the ninth
      // move is reported as a win.
      if (state == CHECK) begin
        if (winner) begin
          win_mark_nxt = who_win;
          over_nxt     = 1'b1;
        end else if (move_count == 4'd9) begin
          draw_nxt = 1'b1;
          over_nxt = 1'b1;
        end else begin
          turn_nxt = ~turn;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      board       <= '0;
      turn        <= FIRST_PLAYER;
      move_count  <= 4'd0;
      move_accept <= 1'b0;
      move_reject <= 1'b0;
      game_over   <= 1'b0;
      draw        <= 1'b0;
      win_mark    <= 2'b00;
`ifdef UNDO_EN
      last_vld    <= 1'b0;
      last_idx    <= 4'd0;
`endif
    end else begin
      board       <= board_nxt;
      turn        <= turn_nxt;
      move_count  <= count_nxt;
      move_accept <= accept_nxt;
      move_reject <= reject_nxt;
      game_over   <= over_nxt;
      draw        <= draw_nxt;
      win_mark    <= win_mark_nxt;
`ifdef UNDO_EN
      last_vld    <= last_vld_nxt;
      last_idx    <= last_idx_nxt;
`endif
    end
  end

  assign pos1 = board[0];
  assign pos2 = board[1];
  assign pos3 = board[2];
  assign pos4 = board[3];
  assign pos5 = board[4];
  assign pos6 = board[5];
  assign pos7 = board[6];
  assign pos8 = board[7];
  assign pos9 = board[8];

endmodule
